// File: rtl/lly_vm_ctrl.sv
// lly_vm_ctrl: vending machine controller. Accepts half-yuan / one-yuan
// coins, vends item A or B, returns change as one pulse per half-yuan, and
// refunds automatically after an idle period in CREDIT.
module lly_vm_ctrl #(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 5,
    parameter int MAX_CREDIT = 15,
    parameter int TIMEOUT    = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] coin_in,
    input  logic [1:0] sel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic [1:0] disp_item,
    output logic       chg_pulse,
    output logic [3:0] credit,
    output logic       coin_rej,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    coin_prev_q, coin_prev_d;
    logic [1:0]    item_q, item_d;
    logic          coin_rej_q, coin_rej_d;

    logic          coin_evt;
    logic [2:0]    coin_val;
    logic [4:0]    coin_sum;
    logic [3:0]    price;
    logic          sel_go;

    // Coin edge detection and selection decode; a held coin counts only on its first cycle.
    always_comb begin
        coin_evt = (coin_prev_q == 2'b00) && ((coin_in == 2'b01) || (coin_in == 2'b10));
        coin_val = coin_evt ? {1'b0, coin_in} : 3'd0;
        coin_sum = {1'b0, credit_q} + {2'b00, coin_val};
        case (sel)
            2'b01:   price = 4'(PRICE_A);
            2'b10:   price = 4'(PRICE_B);
            default: price = 4'd0;
        endcase
        // A selection acts only in CREDIT: cancel always, purchase only if affordable.
        sel_go = (state_q == S_CREDIT) &&
                 ((sel == 2'b11) ||
                  (((sel == 2'b01) || (sel == 2'b10)) && (credit_q >= price)));
    end

    // Next-state, credit, timeout and coin-refusal logic.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        timer_d     = '0;
        item_d      = item_q;
        coin_rej_d  = 1'b0;
        coin_prev_d = coin_in;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (sel_go) begin
                    // Selection wins over a coin arriving in the same cycle.
                    coin_rej_d = coin_evt;
                    if (sel == 2'b11) begin
                        state_d = S_CHANGE;
                    end else begin
                        credit_d = credit_q - price;
                        item_d   = sel;
                        state_d  = S_VEND;
                    end
                end else if (coin_evt && (coin_sum <= 5'(MAX_CREDIT))) begin
                    credit_d = coin_sum[3:0];
                    state_d  = S_CREDIT;
                end else begin
                    coin_rej_d = coin_evt;
                    if (state_q == S_CREDIT) begin
                        if (timer_q == TW'(TIMEOUT - 1)) begin
                            state_d = S_CHANGE;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
            end
            S_VEND: begin
                coin_rej_d = coin_evt;
                if (disp_ack) begin
                    state_d = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_rej_d = coin_evt;
                if (credit_q != 4'd0) begin
                    credit_d = credit_q - 4'd1;
                    if (credit_q == 4'd1) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            credit_q    <= 4'd0;
            timer_q     <= '0;
            coin_prev_q <= 2'b00;
            item_q      <= 2'b00;
            coin_rej_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            timer_q     <= timer_d;
            coin_prev_q <= coin_prev_d;
            item_q      <= item_d;
            coin_rej_q  <= coin_rej_d;
        end
    end

    // Outputs decoded from registered state; a change pulse is one half-yuan leaving.
    always_comb begin
        disp_req  = (state_q == S_VEND);
        disp_item = (state_q == S_VEND) ? item_q : 2'b00;
        chg_pulse = (state_q == S_CHANGE) && (credit_q != 4'd0);
        credit    = credit_q;
        coin_rej  = coin_rej_q;
        busy      = (state_q == S_VEND) || (state_q == S_CHANGE);
    end

endmodule

// File: tb/tb_lly_vm_ctrl.sv
// Testbench for lly_vm_ctrl: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the vending machine.
module tb_lly_vm_ctrl;

    localparam int PA   = 3;
    localparam int PB   = 5;
    localparam int MAXC = 15;
    localparam int TMO  = 64;

    logic       Clk;
    logic       Reset;
    logic [1:0] coin_in;
    logic [1:0] sel;
    logic       disp_ack;
    logic       disp_req;
    logic [1:0] disp_item;
    logic       chg_pulse;
    logic [3:0] credit;
    logic       coin_rej;
    logic       busy;

    lly_vm_ctrl #(
        .PRICE_A(PA), .PRICE_B(PB), .MAX_CREDIT(MAXC), .TIMEOUT(TMO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .coin_in(coin_in), .sel(sel),
        .disp_ack(disp_ack), .disp_req(disp_req), .disp_item(disp_item),
        .chg_pulse(chg_pulse), .credit(credit), .coin_rej(coin_rej),
        .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Observation counters used by directed scenarios.
    int n_req = 0;
    int n_chg = 0;
    int n_rej = 0;

    // Behavioural model: mode 0 idle, 1 holding credit, 2 dispensing, 3 paying change.
    int m_mode   = 0;
    int m_credit = 0;
    int m_prev   = 0;
    int m_idle   = 0;
    int m_item   = 0;
    int m_rej    = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int c, input int s, input int a, input int r);
        int  cv;
        int  price;
        bit  acted;
        if (r != 0) begin
            m_mode = 0; m_credit = 0; m_prev = 0; m_idle = 0; m_item = 0; m_rej = 0;
            return;
        end
        cv     = (m_prev == 0 && (c == 1 || c == 2)) ? c : 0;
        m_prev = c;
        m_rej  = 0;
        price  = (s == 1) ? PA : (s == 2) ? PB : 0;
        if (m_mode <= 1) begin
            acted = (m_mode == 1) && (s == 3 || (price > 0 && m_credit >= price));
            if (acted) begin
                m_rej  = (cv != 0);
                m_idle = 0;
                if (s == 3) m_mode = 3;
                else begin
                    m_credit -= price;
                    m_item    = s;
                    m_mode    = 2;
                end
            end else if (cv != 0 && m_credit + cv <= MAXC) begin
                m_credit += cv;
                m_mode    = 1;
                m_idle    = 0;
            end else begin
                m_rej = (cv != 0);
                if (m_mode == 1) begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_mode = 3;
                        m_idle = 0;
                    end
                end
            end
        end else if (m_mode == 2) begin
            m_rej = (cv != 0);
            if (a != 0) m_mode = (m_credit > 0) ? 3 : 0;
        end else begin
            m_rej = (cv != 0);
            if (m_credit > 0) m_credit--;
            if (m_credit == 0) m_mode = 0;
        end
    endtask

    // One clock: drive inputs, advance model with the edge, compare all outputs after the edge.
    task automatic cycle(input logic [1:0] c, input logic [1:0] s, input logic a);
        coin_in  = c;
        sel      = s;
        disp_ack = a;
        @(posedge Clk);
        model_step(int'(c), int'(s), int'(a), int'(Reset));
        #1;
        chk("disp_req",  8'(disp_req),  8'(m_mode == 2));
        chk("disp_item", 8'(disp_item), 8'((m_mode == 2) ? m_item : 0));
        chk("chg_pulse", 8'(chg_pulse), 8'(m_mode == 3 && m_credit > 0));
        chk("credit",    8'(credit),    8'(m_credit));
        chk("coin_rej",  8'(coin_rej),  8'(m_rej));
        chk("busy",      8'(busy),      8'(m_mode >= 2));
        if (disp_req  === 1'b1) n_req++;
        if (chg_pulse === 1'b1) n_chg++;
        if (coin_rej  === 1'b1) n_rej++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle(2'b00, 2'b00, 1'b0);
        Reset = 1'b0;
    endtask

    // A coin held for two cycles, then released.
    task automatic coin2(input logic [1:0] v);
        cycle(v, 2'b00, 1'b0);
        cycle(v, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
    endtask

    task automatic clr();
        n_req = 0; n_chg = 0; n_rej = 0;
    endtask

    initial begin
        bit coin_sent;
        Reset = 1'b1; coin_in = 2'b00; sel = 2'b00; disp_ack = 1'b0;

        // Reset state
        do_reset();
        chk("rst_credit", 8'(credit), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_disp_item", 8'(disp_item), 8'd0);

        // Coins 2+2+1, buy B, ack after two wait cycles, no change due
        do_reset();
        coin2(2'b10); coin2(2'b10); coin2(2'b01);
        chk("s1_credit5", 8'(credit), 8'd5);
        clr();
        cycle(2'b00, 2'b10, 1'b0);
        chk("s1_item_b", 8'(disp_item), 8'd2);
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(2'b00, 2'b00, 1'b0);
        chk("s1_req_cycles", 8'(n_req), 8'd3);
        chk("s1_no_change", 8'(n_chg), 8'd0);
        chk("s1_credit0", 8'(credit), 8'd0);
        chk("s1_idle", 8'(busy), 8'd0);

        // Credit 6, buy A, ack late, three change pulses
        do_reset();
        coin2(2'b10); coin2(2'b10); coin2(2'b10);
        chk("s2_credit6", 8'(credit), 8'd6);
        clr();
        cycle(2'b00, 2'b01, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) cycle(2'b00, 2'b00, 1'b0);
        chk("s2_req_cycles", 8'(n_req), 8'd3);
        chk("s2_chg_pulses", 8'(n_chg), 8'd3);
        chk("s2_credit0", 8'(credit), 8'd0);

        // Credit ceiling: 14 + 2 refused, 14 + 1 accepted
        do_reset();
        for (int i = 0; i < 7; i++) coin2(2'b10);
        chk("s3_credit14", 8'(credit), 8'd14);
        clr();
        cycle(2'b10, 2'b00, 1'b0);
        chk("s3_rej_pulse", 8'(coin_rej), 8'd1);
        cycle(2'b10, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        chk("s3_rej_once", 8'(n_rej), 8'd1);
        chk("s3_credit_kept", 8'(credit), 8'd14);
        coin2(2'b01);
        chk("s3_credit15", 8'(credit), 8'd15);

        // Unaffordable selection ignored, then cancel refunds 4
        do_reset();
        coin2(2'b10); coin2(2'b10);
        cycle(2'b00, 2'b10, 1'b0);
        chk("s4_ignored_credit", 8'(credit), 8'd4);
        chk("s4_ignored_busy", 8'(busy), 8'd0);
        clr();
        cycle(2'b00, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) cycle(2'b00, 2'b00, 1'b0);
        chk("s4_chg_pulses", 8'(n_chg), 8'd4);
        chk("s4_idle", 8'(busy), 8'd0);

        // Timeout refund of 2 with a coin arriving during change
        do_reset();
        coin2(2'b10);
        clr();
        coin_sent = 1'b0;
        for (int i = 0; i < TMO + 10; i++) begin
            if (busy === 1'b1 && !coin_sent) begin
                coin_sent = 1'b1;
                cycle(2'b01, 2'b00, 1'b0);
            end else begin
                cycle(2'b00, 2'b00, 1'b0);
            end
        end
        chk("s5_chg_pulses", 8'(n_chg), 8'd2);
        chk("s5_rej_in_change", 8'(n_rej), 8'd1);
        chk("s5_credit0", 8'(credit), 8'd0);

        // Reset aborts a pending dispense
        do_reset();
        coin2(2'b10); coin2(2'b10); coin2(2'b10);
        cycle(2'b00, 2'b01, 1'b0);
        chk("s6_in_vend", 8'(disp_req), 8'd1);
        Reset = 1'b1;
        cycle(2'b00, 2'b00, 1'b0);
        Reset = 1'b0;
        chk("s6_req_dropped", 8'(disp_req), 8'd0);
        chk("s6_credit0", 8'(credit), 8'd0);
        chk("s6_idle", 8'(busy), 8'd0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] c;
            logic [1:0] s;
            logic       a;
            c = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            s = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            a = ($urandom_range(0, 9) < 3);
            Reset = ($urandom_range(0, 199) == 0);
            cycle(c, s, a);
        end
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
